// File: rtl/decode_queue_pkg.sv
// Shared pipeline types for the fetch->decode->read path: register types,
// adjustment kinds, operation codes and the decoded read-stage bundle.
package decode_queue_pkg;

    localparam int REGW_P = 5;
    localparam int XLEN_P = 32;

    typedef logic [REGW_P-1:0] regind_t;
    typedef logic [XLEN_P-1:0] regval_t;

    typedef enum logic [1:0] {
        ADJ_ADD   = 2'd0,
        ADJ_LEFT  = 2'd1,
        ADJ_RIGHT = 2'd2,
        ADJ_NONE  = 2'd3
    } adjustment_t;

    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd12;
    localparam logic [3:0] OP_MEM = 4'd14;
    localparam logic [3:0] OP_CX  = 4'd15;

    localparam regind_t PC = 5'd31;

    typedef struct packed {
        logic [3:0]  operation;
        regind_t     destination;
        regind_t     left;
        regind_t     right;
        regind_t     address;
        adjustment_t adjustment_operation;
        regval_t     adjustment_value;
        logic        is_reading_memory;
        logic        is_writing_memory;
    } decoded_t;

endpackage

// File: rtl/decode_queue_instruction_decoder.sv
// Combinational decode of one instruction word into the read-stage bundle,
// plus CNVZ predicate evaluation and the PC-redirect candidate.
module instruction_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [3:0]  flags,
    output decoded_t    bundle,
    output logic        is_valid,
    output logic        is_pc_changing
);

    logic [3:0] op;
    assign op = instruction[26:23];

    always_comb begin
        bundle.operation            = op;
        bundle.destination          = instruction[22:18];
        bundle.left                 = instruction[16:12];
        bundle.right                = '0;
        bundle.address              = instruction[15:11];
        bundle.adjustment_operation = adjustment_t'(instruction[6:5]);
        bundle.adjustment_value     = '0;
        bundle.is_reading_memory    = 1'b0;
        bundle.is_writing_memory    = 1'b0;

        case (op)
            OP_MEM: begin
                bundle.left                 = '0;
                bundle.operation            = OP_OR;
                bundle.adjustment_operation = ADJ_ADD;
                case (instruction[17:16])
                    2'd0: begin
                        bundle.is_reading_memory = 1'b1;
                        bundle.adjustment_value  = {{21{instruction[10]}}, instruction[10:0]};
                    end
                    2'd1: bundle.adjustment_value = {{16{instruction[15]}}, instruction[15:0]};
                    2'd2: begin
                        bundle.operation        = OP_XOR;
                        bundle.left             = instruction[22:18];
                        bundle.adjustment_value = {instruction[15:0], 16'h0};
                    end
                    default: begin
                        bundle.is_writing_memory    = 1'b1;
                        bundle.left                 = instruction[22:18];
                        bundle.adjustment_operation = ADJ_LEFT;
                        bundle.adjustment_value     = {{21{instruction[10]}}, instruction[10:0]};
                    end
                endcase
            end
            OP_CX: begin
                bundle.is_reading_memory    = 1'b1;
                bundle.is_writing_memory    = 1'b1;
                bundle.address              = instruction[6:2];
                bundle.adjustment_operation = ADJ_ADD;
            end
            default: begin
                if (instruction[17]) begin
                    bundle.right            = instruction[11:7];
                    bundle.adjustment_value = {{27{instruction[4]}}, instruction[4:0]};
                end else begin
                    bundle.adjustment_operation = ADJ_ADD;
                    bundle.adjustment_value     = {{20{instruction[11]}}, instruction[11:0]};
                end
            end
        endcase
    end

    // Predicate bit 31 selects whether the masked flags must be set or clear.
    assign is_valid       = instruction[31] == |(instruction[30:27] & flags);
    assign is_pc_changing = is_valid && (!bundle.is_writing_memory || bundle.is_reading_memory)
                            && (bundle.destination == PC);

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry queue decoupling fetch from read stalls; 2-cycle min latency,
// in_hold when full, out_hold freezes the output. Optional counters: DECODE_QUEUE_PERF_EN.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int REGW  = 5
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [3:0]                 flags,
    input  logic                       in_valid,
    input  logic [31:0]                in_instruction,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       in_hold,
    output logic                       is_pc_changing,
    input  logic                       out_hold,
    output logic                       out_is_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [3:0]                 out_operation,
    output logic [REGW-1:0]            out_destination_register,
    output logic [REGW-1:0]            out_left_register,
    output logic [REGW-1:0]            out_right_register,
    output logic [REGW-1:0]            out_address_register,
    output logic [1:0]                 out_adjustment_operation,
    output logic [XLEN-1:0]            out_adjustment_value,
    output logic                       out_is_reading_memory,
    output logic                       out_is_writing_memory,
    output logic                       out_has_flushed,
    output logic [$clog2(DEPTH):0]     out_occupancy
`ifdef DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]                out_issued_count,
    output logic [31:0]                out_squashed_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [31:0]     q_instruction [DEPTH];
    logic [XLEN-1:0] q_pc [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   occupancy;

    decoded_t head;
    logic     head_valid, head_redirect;
    logic     issuing, push;

    instruction_decoder u_decoder (
        .instruction    (q_instruction[rd_ptr]),
        .flags          (flags),
        .bundle         (head),
        .is_valid       (head_valid),
        .is_pc_changing (head_redirect)
    );

    assign issuing        = !out_hold && (occupancy != '0);
    assign is_pc_changing = issuing && head_redirect;
    assign in_hold        = (occupancy == OW'(DEPTH)) && reset_n;
    assign push           = in_valid && !in_hold && !is_pc_changing;
    assign out_occupancy  = occupancy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (is_pc_changing) begin
            rd_ptr    <= wr_ptr;
            occupancy <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (issuing) rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + OW'(push) - OW'(issuing);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_instruction[wr_ptr] <= in_instruction;
            q_pc[wr_ptr]          <= in_pc;
        end
    end

    // An empty queue loads a bubble: 1-bit outputs drop, data fields keep their values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_is_valid             <= 1'b0;
            out_pc                   <= '0;
            out_operation            <= '0;
            out_destination_register <= '0;
            out_left_register        <= '0;
            out_right_register       <= '0;
            out_address_register     <= '0;
            out_adjustment_operation <= '0;
            out_adjustment_value     <= '0;
            out_is_reading_memory    <= 1'b0;
            out_is_writing_memory    <= 1'b0;
            out_has_flushed          <= 1'b0;
        end else if (!out_hold) begin
            if (issuing) begin
                out_is_valid             <= head_valid;
                out_pc                   <= q_pc[rd_ptr];
                out_operation            <= head.operation;
                out_destination_register <= head.destination;
                out_left_register        <= head.left;
                out_right_register       <= head.right;
                out_address_register     <= head.address;
                out_adjustment_operation <= head.adjustment_operation;
                out_adjustment_value     <= head.adjustment_value;
                out_is_reading_memory    <= head.is_reading_memory;
                out_is_writing_memory    <= head.is_writing_memory;
                out_has_flushed          <= is_pc_changing;
            end else begin
                out_is_valid          <= 1'b0;
                out_is_reading_memory <= 1'b0;
                out_is_writing_memory <= 1'b0;
                out_has_flushed       <= 1'b0;
            end
        end
    end

`ifdef DECODE_QUEUE_PERF_EN
    // A flush discards every entry behind the head plus any offer fetch made that cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_issued_count   <= '0;
            out_squashed_count <= '0;
        end else begin
            if (issuing) out_issued_count <= out_issued_count + 32'd1;
            if (is_pc_changing)
                out_squashed_count <= out_squashed_count + 32'(occupancy) - 32'd1
                                      + 32'(in_valid && !in_hold);
        end
    end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4).
module tb_decode_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  flags;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        in_hold;
    logic        is_pc_changing;
    logic        out_hold;
    logic        out_is_valid;
    logic [31:0] out_pc;
    logic [3:0]  out_operation;
    logic [4:0]  out_destination_register, out_left_register;
    logic [4:0]  out_right_register, out_address_register;
    logic [1:0]  out_adjustment_operation;
    logic [31:0] out_adjustment_value;
    logic        out_is_reading_memory, out_is_writing_memory, out_has_flushed;
    logic [2:0]  out_occupancy;
`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] out_issued_count, out_squashed_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    decode_queue #(.DEPTH(4), .XLEN(32), .REGW(5)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .flags                    (flags),
        .in_valid                 (in_valid),
        .in_instruction           (in_instruction),
        .in_pc                    (in_pc),
        .in_hold                  (in_hold),
        .is_pc_changing           (is_pc_changing),
        .out_hold                 (out_hold),
        .out_is_valid             (out_is_valid),
        .out_pc                   (out_pc),
        .out_operation            (out_operation),
        .out_destination_register (out_destination_register),
        .out_left_register        (out_left_register),
        .out_right_register       (out_right_register),
        .out_address_register     (out_address_register),
        .out_adjustment_operation (out_adjustment_operation),
        .out_adjustment_value     (out_adjustment_value),
        .out_is_reading_memory    (out_is_reading_memory),
        .out_is_writing_memory    (out_is_writing_memory),
        .out_has_flushed          (out_has_flushed),
        .out_occupancy            (out_occupancy)
`ifdef DECODE_QUEUE_PERF_EN
        ,
        .out_issued_count         (out_issued_count),
        .out_squashed_count       (out_squashed_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
        step();
        in_valid       = 1'b0;
    endtask

    function automatic logic [31:0] f_ldi(input logic [4:0] rd, input logic [15:0] imm);
        return {1'b0, 4'b0000, 4'd14, rd, 2'd1, imm};
    endfunction
    function automatic logic [31:0] f_xorih(input logic [4:0] rd, input logic [15:0] imm);
        return {1'b0, 4'b0000, 4'd14, rd, 2'd2, imm};
    endfunction
    function automatic logic [31:0] f_st(input logic [4:0] rd, input logic [10:0] off);
        return {1'b0, 4'b0000, 4'd14, rd, 2'd3, 5'd0, off};
    endfunction
    // Predicated on Z set: bit31=1, mask=0001, op 0 immediate form.
    function automatic logic [31:0] f_pred();
        return {1'b1, 4'b0001, 4'd0, 5'd9, 1'b0, 5'd2, 12'h005};
    endfunction

    initial begin
        reset_n = 1'b0; flags = 4'd0; in_valid = 1'b0; in_instruction = '0;
        in_pc = '0; out_hold = 1'b0;
        #2;
        check("rst_occupancy", 32'(out_occupancy), 32'd0);
        check("rst_valid", 32'(out_is_valid), 32'd0);
        check("rst_in_hold", 32'(in_hold), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_adj_value", out_adjustment_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // ldi r3, 0xFFFF: bubble after push edge, instruction after the next edge.
        push_one(f_ldi(5'd3, 16'hFFFF), 32'h100);
        check("ldi_occ_after_push", 32'(out_occupancy), 32'd1);
        check("ldi_not_yet_valid", 32'(out_is_valid), 32'd0);
        step();
        check("ldi_valid", 32'(out_is_valid), 32'd1);
        check("ldi_operation", 32'(out_operation), 32'd10);
        check("ldi_value", out_adjustment_value, 32'hFFFF_FFFF);
        check("ldi_read", 32'(out_is_reading_memory), 32'd0);
        check("ldi_dest", 32'(out_destination_register), 32'd3);
        check("ldi_pc", out_pc, 32'h100);
        check("ldi_occ_after_issue", 32'(out_occupancy), 32'd0);

        // Fill under out_hold; fifth offer is held off.
        out_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_one(f_ldi(5'(i + 1), 16'(i)), 32'h200 + 32'(4 * i));
        check("full_occ", 32'(out_occupancy), 32'd4);
        check("full_in_hold", 32'(in_hold), 32'd1);
        in_valid = 1'b1; in_instruction = f_ldi(5'd5, 16'd4); in_pc = 32'h210;
        step();
        check("full_occ_held", 32'(out_occupancy), 32'd4);
        check("held_output_pc", out_pc, 32'h100);
        out_hold = 1'b0;
        #1;
        check("full_pop_in_hold", 32'(in_hold), 32'd1);
        step();
        check("drain0_pc", out_pc, 32'h200);
        check("drain0_dest", 32'(out_destination_register), 32'd1);
        check("drain0_occ", 32'(out_occupancy), 32'd3);
        step();
        in_valid = 1'b0;
        check("pushpop_occ", 32'(out_occupancy), 32'd3);
        check("drain1_dest", 32'(out_destination_register), 32'd2);
        for (int i = 2; i < 5; i++) begin
            step();
            check("drain_pc", out_pc, 32'h200 + 32'(4 * i));
            check("drain_dest", 32'(out_destination_register), 32'(i + 1));
        end
        check("drain_occ_empty", 32'(out_occupancy), 32'd0);
        step();
        check("bubble_valid", 32'(out_is_valid), 32'd0);
        check("bubble_pc_kept", out_pc, 32'h210);

        // Predicate on Z.
        push_one(f_pred(), 32'h280);
        step();
        check("pred_z0_valid", 32'(out_is_valid), 32'd0);
        check("pred_z0_pc", out_pc, 32'h280);
        flags = 4'b0001;
        push_one(f_pred(), 32'h284);
        step();
        check("pred_z1_valid", 32'(out_is_valid), 32'd1);
        flags = 4'b0000;

        // Flush: ldi to PC at head with two younger entries.
        out_hold = 1'b1;
        push_one(f_ldi(5'd31, 16'h0040), 32'h300);
        push_one(f_ldi(5'd1, 16'h0001), 32'h304);
        push_one(f_ldi(5'd2, 16'h0002), 32'h308);
        out_hold = 1'b0;
        #1;
        check("flush_pc_changing", 32'(is_pc_changing), 32'd1);
        step();
        check("flush_flag", 32'(out_has_flushed), 32'd1);
        check("flush_pc", out_pc, 32'h300);
        check("flush_valid", 32'(out_is_valid), 32'd1);
        check("flush_occ", 32'(out_occupancy), 32'd0);
        step();
        check("post_flush_bubble", 32'(out_is_valid), 32'd0);
        check("post_flush_flag", 32'(out_has_flushed), 32'd0);
`ifdef DECODE_QUEUE_PERF_EN
        check("squashed_count", out_squashed_count, 32'd2);
`endif

        // Flush with a simultaneous push: the push is dropped.
        out_hold = 1'b1;
        push_one(f_ldi(5'd31, 16'h0080), 32'h400);
        out_hold = 1'b0;
        in_valid = 1'b1; in_instruction = f_ldi(5'd7, 16'h0007); in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        check("drop_flush_flag", 32'(out_has_flushed), 32'd1);
        check("drop_occ", 32'(out_occupancy), 32'd0);
        step();
        check("drop_bubble", 32'(out_is_valid), 32'd0);
        check("drop_pc_kept", out_pc, 32'h400);
`ifdef DECODE_QUEUE_PERF_EN
        check("squashed_count_drop", out_squashed_count, 32'd3);
`endif

        // xorih and store back to back.
        push_one(f_xorih(5'd5, 16'h1234), 32'h500);
        push_one(f_st(5'd6, 11'h7FF), 32'h504);
        check("xorih_left", 32'(out_left_register), 32'd5);
        check("xorih_op", 32'(out_operation), 32'd12);
        check("xorih_value", out_adjustment_value, 32'h1234_0000);
        step();
        check("st_write", 32'(out_is_writing_memory), 32'd1);
        check("st_read", 32'(out_is_reading_memory), 32'd0);
        check("st_adj_left", 32'(out_adjustment_operation), 32'd1);
        check("st_value", out_adjustment_value, 32'hFFFF_FFFF);
        check("st_left", 32'(out_left_register), 32'd6);

        // Asynchronous reset with three entries queued.
        out_hold = 1'b1;
        for (int i = 0; i < 3; i++) push_one(f_ldi(5'(i + 8), 16'(i)), 32'h600 + 32'(4 * i));
        check("prerst_occ", 32'(out_occupancy), 32'd3);
        check("prerst_valid", 32'(out_is_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_occ", 32'(out_occupancy), 32'd0);
        check("midrst_valid", 32'(out_is_valid), 32'd0);
        out_hold = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
        check("postrst_valid", 32'(out_is_valid), 32'd0);
        check("postrst_occ", 32'(out_occupancy), 32'd0);
        check("postrst_pc", out_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with a DEPTH-entry instruction queue between fetch and read. Fetch is decoupled from read-stage stalls. Each cycle the head instruction is evaluated against the CNVZ flags, decoded into the read-stage bundle, and registered. On a PC-changing issue, all younger queued and incoming instructions are squashed. It replaces the fixed single-slot decode in the fetch→decode→read pipeline.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 32: register/immediate width.
- REGW, 5: register-index width.
- clock  in  1  pipeline clock
- reset_n  in  1  reset, asynchronous, active-low
- flags  in  4  CNVZ flags (Flags register bits 30:27)
- in_valid  in  1  fetch offers an instruction
- in_instruction  in  32  instruction word
- in_pc  in  XLEN  its PC
- in_hold  out  1  queue full; fetch must keep its offer
- is_pc_changing  out  1  the issuing instruction redirects PC (combinational)
- out_hold  in  1  read stage stalls; the output register holds
- out_is_valid, out_pc, out_operation[4], out_destination_register, out_left_register, out_right_register, out_address_register[REGW], out_adjustment_operation[2], out_adjustment_value[XLEN], out_is_reading_memory, out_is_writing_memory, out_has_flushed  out  registered read-stage bundle
- out_occupancy  out  $clog2(DEPTH)+1  entries queued

## Operation
- Push when in_valid && !in_hold. in_hold = (occupancy==DEPTH) && reset_n.
- Issue when !out_hold. If the queue is non-empty, pop the head, decode it, and load the output register. If the queue is empty, load a bubble: all 1-bit outputs are 0, and other fields keep their values.
- Predicate: masked = |(instr[30:27] & flags); is_valid = instr[31]==masked. Flags are sampled in the issue cycle.
- Decode field map:
  - op[26:23], rd[22:18], isreg[17], sr1[16:12], imm12[11:0], sr2[11:7], adjop[6:5], adj5[4:0]
  - mop[17:16], ar[15:11], off11[10:0], imm16[15:0], xar[6:2]
- op 14: left=0, right=0, operation=OR(10), adj=Add.
  - mop0 ld: read, value=sext(off11).
  - mop1 ldi: value=sext(imm16).
  - mop2 xorih: operation=XOR(12), left=rd, value={imm16,16'h0}.
  - mop3 st: write, left=rd, adj=Left, value=sext(off11).
- op 15 cx: read+write, address=xar, adj=Add, value=0.
- Other ops: if isreg, value=sext(adj5) and right=sr2. Otherwise right=0, adj=Add, value=sext(imm12).
- Defaults: address=ar, left=sr1, adjustment_operation=adjop.
- is_pc_changing = issuing && is_valid && (!write || read) && rd==PC(31).
- On is_pc_changing:
  - The queue is cleared.
  - A simultaneous push is dropped.
  - out_has_flushed is loaded with 1 alongside the redirecting instruction. It is 0 for every other load.
- Squashed instructions never appear at the output.

## Timing
- Reset (async): queue empty; out_occupancy 0; all 1-bit outputs 0; out_pc, out_adjustment_value and the register indices 0.
- Latency: pushed at edge N, visible at the output after edge N+1 (2 cycles minimum).
- Push and pop in the same cycle: occupancy is unchanged. When full with a simultaneous pop, in_hold stays 1 (no full-bypass).
- out_hold=1: no pop and the output register holds. Pushes continue until full.
- Pointer wrap is modulo DEPTH. Occupancy never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation clears all queued state immediately.

## Configuration
- DECODE_QUEUE_PERF_EN defined: adds out_issued_count and out_squashed_count (32-bit, wrapping, reset 0).
  - issued_count increments per non-bubble load.
  - squashed_count increments by the number of entries discarded on a flush, including a dropped push.
- Undefined: the counters and their ports are absent.

## Structure
- Shared pipeline package holds:
  - regind_t
  - regval_t
  - adjustment enum (Add, Left, …)
  - operation codes OR=10, XOR=12, MEM=14, CX=15
  - PC=31
  - decoded-bundle struct
- One sub-module: instruction_decoder. It is combinational: instruction+flags → bundle, is_valid, is_pc_changing-candidate.
- Queue and pointers live in decode_queue.

## Test plan
- Reset, then push a ldi to r3 with imm16=0xFFFF → 2 cycles later: out_is_valid=1, operation=10, adjustment_value=0xFFFFFFFF, read=0.
- Hold out_hold=1 and push 5 instructions with DEPTH=4 → in_hold=1 after 4 pushes, occupancy=4; release → issued in order, one per cycle.
- Predicate: mask=0001, flags Z=0, bit31=1 → out_is_valid=0. Set Z=1 → out_is_valid=1.
- Queue 3 entries, head is ldi to PC → out_has_flushed=1 with it, occupancy→0, next load is a bubble, squashed_count=2.
- xorih rd=r5 imm16=0x1234 → left=5, operation=12, value=0x12340000. Store off11=0x7FF → write=1, adj=Left, value=0xFFFFFFFF.
- Reset asserted with 3 queued → occupancy 0 and out_is_valid 0 immediately; nothing issues after release.
